serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop. It is the inverse-operation counterpart of the team's bit-serial adder datapath and shares its load/shift/collect structure. It sits beside the serial adder in the arithmetic section and gives area-cheap difference and compare results to control logic that can tolerate WIDTH+1 cycles of latency.

## Interface
- `WIDTH`, 8, operand width in bits; legal range is 2 to 32.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only while idle.
- `a`  in  WIDTH  minuend, unsigned; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend, unsigned; captured on the accepting edge.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `diff` and `borrow` are valid from this cycle on.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow`  out  1  final borrow; 1 exactly when `a < b`.

## Operation
- The FSM has two states, IDLE and SHIFT.
  - IDLE to SHIFT: on an edge with `start`=1. On that edge, load `a` into the A shift register and `b` into the B shift register, clear the borrow flop, clear the bit counter, and clear the D collect register.
  - SHIFT: on each edge, shift A and B right by one. Compute the current bit as `d = a0 ^ b0 ^ br`. Compute the next borrow as `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`. Shift D right with `d` inserted at the MSB, and increment the counter.
  - SHIFT to IDLE: on the edge that processes bit WIDTH-1. On that same edge, write `diff` from the final D contents (including the last `d`), write `borrow` from `br'`, and assert `done`.
- `busy` = (state == SHIFT).
- `start` is ignored while busy. `a` and `b` may change freely after the accepting edge.
- `diff` and `borrow` hold their last result until the next completion. They are not cleared at start.
- Width rules:
  - The counter is `$clog2(WIDTH)` bits and counts 0 to WIDTH-1.
  - There is no wrap-around: the exit is decoded at count WIDTH-1.
  - The result equals `{borrow, diff} = {1'b0, a} - {1'b0, b}` taken as a WIDTH+1-bit two's-complement value.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0. The borrow flop, counter and shift registers are also 0.
- Latency: if `start` is accepted at edge T, bits are processed at edges T+1 through T+WIDTH. `done`=1 and the results are valid in the cycle after edge T+WIDTH.
- `busy` is high in the cycles following edges T through T+WIDTH-1. `busy` and `done` are never high together.
- Back-to-back operation: the cycle in which `done` is high is an IDLE cycle, so `start` can be accepted at edge T+WIDTH+1. The throughput is one result per WIDTH+1 cycles.
- Reset mid-operation: asserting `rst` aborts immediately and asynchronously, and all outputs go to their reset values. No `done` is produced. The first `start` after `rst` deasserts behaves normally.
- `start` held high continuously: a new operation begins at every possible accept edge, using the operand values present on that edge.

## Structure
- Shared package `serial_arith_pkg`:
  - `state_t` enum (IDLE, SHIFT), shared with the serial adder controller.
  - Localparam helpers for counter width.
- One sub-module: `full_subtractor`, a purely combinational cell with inputs `a, b, bin` and outputs `d, bout`, using the equations above. It is instantiated once. The borrow flop lives in `serial_subtractor`.
- Everything else (FSM, counter, three shift registers, result registers) is in a single `always` block per clocked concern, using async-reset flops.

## Test plan
- WIDTH=8, a=200, b=55, start pulsed at edge T: `done` after edge T+8, `diff`=8'h91 (145), `borrow`=0, `busy` high for exactly 8 cycles.
- WIDTH=8, a=5, b=9: `diff`=8'hFC, `borrow`=1. Then a=8'hAA, b=8'hAA: `diff`=0, `borrow`=0. Then a=0, b=8'hFF: `diff`=8'h01, `borrow`=1.
- `start` held high for 40 cycles with operands changing every cycle: `done` pulses every 9 cycles. Each result matches the operands present on its accept edge. Pulses of `start` mid-operation have no effect.
- `rst` asserted asynchronously (mid-cycle) while processing bit 4: `busy`, `done`, `diff` and `borrow` drop to 0 immediately with no `done` pulse. A following op with a=100, b=1 gives `diff`=99, `borrow`=0.
- WIDTH=16, a=16'h8000, b=16'h0001: `done` after edge T+16, `diff`=16'h7FFF, `borrow`=0.
- Randomized self-check, 1000 ops at WIDTH=8 and WIDTH=13: `{borrow, diff}` matches the reference model `{1'b0,a}-{1'b0,b}`. `diff` holds steady between `done` pulses.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and sizing helpers for the bit-serial arithmetic datapaths
`timescale 1ns/1ps
package serial_arith_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // Bit counter width for an operand of w bits; counts 0 .. w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
`timescale 1ns/1ps
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_axb;

    // Difference bit and outgoing borrow of a - b - bin
    always_comb begin
        w_axb  = i_a ^ i_b;
        o_d    = w_axb ^ i_bin;
        o_bout = (~i_a & i_b) | (~w_axb & i_bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
`timescale 1ns/1ps
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_d_next;

    full_subtractor u_fs (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_br),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // Handshake decode and the collect register with the new bit entering at the MSB
    always_comb begin
        w_accept = (r_state == IDLE) && i_start;
        w_step   = (r_state == SHIFT);
        w_last   = w_step && (r_cnt == LAST);
        w_d_next = {w_d, r_d[WIDTH-1:1]};
    end

    // Controller: state, bit counter and the one-cycle done pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand shift registers, borrow flop and difference collector
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_d  <= '0;
            r_br <= 1'b0;
        end else if (w_accept) begin
            r_a  <= i_a;
            r_b  <= i_b;
            r_d  <= '0;
            r_br <= 1'b0;
        end else if (w_step) begin
            r_a  <= r_a >> 1;
            r_b  <= r_b >> 1;
            r_d  <= w_d_next;
            r_br <= w_bout;
        end
    end

    // Result registers: updated only on the final bit, held until the next completion
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_last) begin
            r_diff   <= w_d_next;
            r_borrow <= w_bout;
        end
    end

    assign o_busy   = (r_state == SHIFT);
    assign o_done   = r_done;
    assign o_diff   = r_diff;
    assign o_borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8, 13 and 16
`timescale 1ns/1ps
module tb_serial_subtractor;

    logic clk;
    logic rst;

    logic        start8,  start13,  start16;
    logic [7:0]  a8,  b8;
    logic [12:0] a13, b13;
    logic [15:0] a16, b16;
    logic        busy8,  busy13,  busy16;
    logic        done8,  done13,  done16;
    logic [7:0]  diff8;
    logic [12:0] diff13;
    logic [15:0] diff16;
    logic        borrow8, borrow13, borrow16;

    int total = 0;
    int bad   = 0;

    logic [63:0] prev_diff [3];
    logic        prev_br   [3];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8),
        .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(13)) dut13 (
        .i_clk(clk), .i_rst(rst), .i_start(start13), .i_a(a13), .i_b(b13),
        .o_busy(busy13), .o_done(done13), .o_diff(diff13), .o_borrow(borrow13)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start16), .i_a(a16), .i_b(b16),
        .o_busy(busy16), .o_done(done16), .o_diff(diff16), .o_borrow(borrow16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 13 : 16;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy8 : (sel == 1) ? busy13 : busy16;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done8 : (sel == 1) ? done13 : done16;
    endfunction

    function automatic logic [63:0] get_diff(input int sel);
        return (sel == 0) ? 64'(diff8) : (sel == 1) ? 64'(diff13) : 64'(diff16);
    endfunction

    function automatic logic get_borrow(input int sel);
        return (sel == 0) ? borrow8 : (sel == 1) ? borrow13 : borrow16;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [31:0] av, input logic [31:0] bv);
        case (sel)
            0: begin start8  = st; a8  = av[7:0];  b8  = bv[7:0];  end
            1: begin start13 = st; a13 = av[12:0]; b13 = bv[12:0]; end
            default: begin start16 = st; a16 = av[15:0]; b16 = bv[15:0]; end
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {borrow, diff} is the WIDTH+1-bit value of a - b with a zero-extended
    task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv,
                         output logic [63:0] ed, output logic eb);
        logic [63:0] mask;
        logic [63:0] full;
        mask = (64'd1 << w) - 64'd1;
        full = (64'(av) & mask) - (64'(bv) & mask);
        ed   = full & mask;
        eb   = full[w];
    endtask

    // One complete operation: checks latency, busy length, pulse width, hold and result
    task automatic do_op(input int sel, input logic [31:0] av, input logic [31:0] bv, input string tag);
        int          w;
        int          lat;
        int          busy_cnt;
        bit          got;
        logic [63:0] ed;
        logic        eb;
        w = width_of(sel);
        model(w, av, bv, ed, eb);
        @(negedge clk);
        drive(sel, 1'b1, av, bv);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, $urandom, $urandom);
        lat      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int k = 1; k <= w + 3 && !got; k++) begin
            @(negedge clk);
            drive(sel, 1'b0, $urandom, $urandom);
            if (get_busy(sel) && get_done(sel))
                check({tag, "_busy_and_done"}, 64'd1, 64'd0);
            if (get_done(sel)) begin
                got = 1'b1;
                lat = k;
            end else begin
                if (get_busy(sel)) busy_cnt++;
                if (get_diff(sel) !== prev_diff[sel])
                    check({tag, "_diff_hold"}, get_diff(sel), prev_diff[sel]);
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(w + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(w));
        check({tag, "_diff"}, get_diff(sel), ed);
        check({tag, "_borrow"}, 64'(get_borrow(sel)), 64'(eb));
        prev_diff[sel] = ed;
        prev_br[sel]   = eb;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(get_done(sel)), 64'd0);
        check({tag, "_diff_after"}, get_diff(sel), ed);
    endtask

    initial begin
        logic [63:0] ed;
        logic        eb;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp_d [$];
        logic        exp_b [$];
        int          ndone;
        int          last_done;
        int          cyc;

        rst = 1'b1;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        drive(2, 1'b0, 0, 0);
        for (int s = 0; s < 3; s++) begin
            prev_diff[s] = '0;
            prev_br[s]   = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset_busy",   64'(get_busy(s)),   64'd0);
            check("reset_done",   64'(get_done(s)),   64'd0);
            check("reset_diff",   get_diff(s),        64'd0);
            check("reset_borrow", 64'(get_borrow(s)), 64'd0);
        end
        rst = 1'b0;

        // Directed operations
        do_op(0, 200, 55, "w8_200_55");
        check("w8_200_55_const", prev_diff[0], 64'h91);
        do_op(0, 5, 9, "w8_5_9");
        check("w8_5_9_const", {prev_diff[0][62:0], prev_br[0]}, {63'hFC, 1'b1});
        do_op(0, 32'hAA, 32'hAA, "w8_aa_aa");
        do_op(0, 0, 32'hFF, "w8_0_ff");
        check("w8_0_ff_const", {prev_diff[0][62:0], prev_br[0]}, {63'h01, 1'b1});
        do_op(2, 32'h8000, 32'h0001, "w16_8000_1");
        check("w16_8000_1_const", prev_diff[2], 64'h7FFF);

        // Asynchronous reset while bit 4 is in flight
        @(negedge clk);
        drive(0, 1'b1, 77, 3);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 0, 0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy",   64'(busy8),   64'd0);
        check("arst_done",   64'(done8),   64'd0);
        check("arst_diff",   64'(diff8),   64'd0);
        check("arst_borrow", 64'(borrow8), 64'd0);
        for (int s = 0; s < 3; s++) begin
            prev_diff[s] = '0;
            prev_br[s]   = 1'b0;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done8) check("arst_no_done", 64'(done8), 64'd0);
        end
        rst = 1'b0;
        do_op(0, 100, 1, "w8_after_rst");
        check("w8_after_rst_const", prev_diff[0], 64'd99);

        // start held high with operands changing every cycle
        ndone     = 0;
        last_done = -1;
        for (int i = 0; i < 52; i++) begin
            @(negedge clk);
            if (done8) begin
                check("hold_pending", 64'(exp_d.size() > 0), 64'd1);
                if (exp_d.size() > 0) begin
                    ed = exp_d.pop_front();
                    eb = exp_b.pop_front();
                    check("hold_diff",   64'(diff8),   ed);
                    check("hold_borrow", 64'(borrow8), 64'(eb));
                end
                if (last_done >= 0) check("hold_period", 64'(i - last_done), 64'd9);
                last_done = i;
                ndone++;
            end
            if (i < 40) begin
                ra = $urandom;
                rb = $urandom;
                drive(0, 1'b1, ra, rb);
                if (i % 9 == 0) begin
                    model(8, ra, rb, ed, eb);
                    exp_d.push_back(ed);
                    exp_b.push_back(eb);
                end
            end else begin
                drive(0, 1'b0, 0, 0);
            end
        end
        check("hold_done_count", 64'(ndone), 64'd5);
        check("hold_queue_empty", 64'(exp_d.size()), 64'd0);
        model(8, 0, 0, ed, eb);
        prev_diff[0] = 64'(diff8);
        prev_br[0]   = borrow8;

        // Randomized operations at WIDTH 8 and 13
        for (int n = 0; n < 1000; n++) begin
            do_op(0, $urandom, $urandom, "rand_w8");
            do_op(1, $urandom, $urandom, "rand_w13");
        end

        // Edge operands at WIDTH 13
        do_op(1, 0, 32'h1FFF, "w13_0_max");
        do_op(1, 32'h1FFF, 0, "w13_max_0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
